rs_param: RTL and testbench

- Parametrised reservation station, successor to the fixed 3+3 station.
- Sits between decode/rename dispatch and the ALU and memory units.
- Holds ALU_DEPTH ALU-class and MEM_DEPTH memory-class entries as age-ordered compacting queues.
- Wakes operands from two common data buses (CDBs) and issues over valid/ready handshakes; ALU issues oldest-ready-first, memory strictly in order; flush supported.

---
 rtl/rs_param.sv | 277 +++++++++++++++++++++++++++
 tb/tb_rs_param.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_param.sv
// Reservation station with ALU_DEPTH ALU-class and MEM_DEPTH memory-class entries held in
// age-ordered compacting queues; CDB wakeup and valid/ready issue per class.
module rs_param #(
    parameter int         ALU_DEPTH = 4,
    parameter int         MEM_DEPTH = 4,
    parameter int         TAG_W     = 3,
    parameter int         DATA_W    = 32,
    parameter logic [4:0] MEM_OP_LO = 5'b10010,
    parameter logic [4:0] MEM_OP_HI = 5'b11001
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic                               disp_valid,
    output logic                               disp_ready,
    input  logic [4:0]                         disp_op,
    input  logic [DATA_W-1:0]                  disp_v1,
    input  logic [DATA_W-1:0]                  disp_v2,
    input  logic [TAG_W-1:0]                   disp_q1,
    input  logic [TAG_W-1:0]                   disp_q2,
    input  logic [DATA_W-1:0]                  disp_imm,
    input  logic [TAG_W-1:0]                   disp_tag,
    input  logic                               cdb0_valid,
    input  logic [TAG_W-1:0]                   cdb0_tag,
    input  logic [DATA_W-1:0]                  cdb0_data,
    input  logic                               cdb1_valid,
    input  logic [TAG_W-1:0]                   cdb1_tag,
    input  logic [DATA_W-1:0]                  cdb1_data,
    output logic                               alu_valid,
    input  logic                               alu_ready,
    output logic [4:0]                         alu_op,
    output logic [DATA_W-1:0]                  alu_v1,
    output logic [DATA_W-1:0]                  alu_v2,
    output logic [DATA_W-1:0]                  alu_imm,
    output logic [TAG_W-1:0]                   alu_tag,
    output logic                               mem_valid,
    input  logic                               mem_ready,
    output logic [4:0]                         mem_op,
    output logic [DATA_W-1:0]                  mem_v1,
    output logic [DATA_W-1:0]                  mem_v2,
    output logic [DATA_W-1:0]                  mem_imm,
    output logic [TAG_W-1:0]                   mem_tag,
    output logic [$clog2(ALU_DEPTH+1)-1:0]     alu_count,
    output logic [$clog2(MEM_DEPTH+1)-1:0]     mem_count
);
    logic is_mem;
    logic alu_full;
    logic mem_full;
    logic alu_push;
    logic mem_push;

    assign is_mem     = (disp_op >= MEM_OP_LO) && (disp_op <= MEM_OP_HI);
    // Readiness looks at the current occupancy only; an issue in the same cycle frees no slot.
    assign disp_ready = !flush && (is_mem ? !mem_full : !alu_full);
    assign alu_push   = disp_valid && disp_ready && !is_mem;
    assign mem_push   = disp_valid && disp_ready && is_mem;

    rs_queue #(
        .DEPTH(ALU_DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .IN_ORDER(1'b0)
    ) u_alu_q (
        .clk(clk), .rst(rst), .flush(flush), .push(alu_push),
        .in_op(disp_op), .in_v1(disp_v1), .in_v2(disp_v2), .in_imm(disp_imm),
        .in_q1(disp_q1), .in_q2(disp_q2), .in_tag(disp_tag),
        .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
        .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
        .out_ready(alu_ready), .out_valid(alu_valid), .out_op(alu_op),
        .out_v1(alu_v1), .out_v2(alu_v2), .out_imm(alu_imm), .out_tag(alu_tag),
        .count(alu_count), .full(alu_full)
    );

    rs_queue #(
        .DEPTH(MEM_DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W), .IN_ORDER(1'b1)
    ) u_mem_q (
        .clk(clk), .rst(rst), .flush(flush), .push(mem_push),
        .in_op(disp_op), .in_v1(disp_v1), .in_v2(disp_v2), .in_imm(disp_imm),
        .in_q1(disp_q1), .in_q2(disp_q2), .in_tag(disp_tag),
        .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
        .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
        .out_ready(mem_ready), .out_valid(mem_valid), .out_op(mem_op),
        .out_v1(mem_v1), .out_v2(mem_v2), .out_imm(mem_imm), .out_tag(mem_tag),
        .count(mem_count), .full(mem_full)
    );
endmodule

// One class queue: entries [0, count) are valid, index 0 is oldest. IN_ORDER restricts
// issue to the head; otherwise the oldest ready entry issues.
module rs_queue #(
    parameter int DEPTH    = 4,
    parameter int TAG_W    = 3,
    parameter int DATA_W   = 32,
    parameter bit IN_ORDER = 1'b0,
    parameter int CNT_W    = $clog2(DEPTH+1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [4:0]        in_op,
    input  logic [DATA_W-1:0] in_v1,
    input  logic [DATA_W-1:0] in_v2,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [TAG_W-1:0]  in_q1,
    input  logic [TAG_W-1:0]  in_q2,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              cdb0_valid,
    input  logic [TAG_W-1:0]  cdb0_tag,
    input  logic [DATA_W-1:0] cdb0_data,
    input  logic              cdb1_valid,
    input  logic [TAG_W-1:0]  cdb1_tag,
    input  logic [DATA_W-1:0] cdb1_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [4:0]        out_op,
    output logic [DATA_W-1:0] out_v1,
    output logic [DATA_W-1:0] out_v2,
    output logic [DATA_W-1:0] out_imm,
    output logic [TAG_W-1:0]  out_tag,
    output logic [CNT_W-1:0]  count,
    output logic              full
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic [4:0]        op;
        logic [DATA_W-1:0] v1;
        logic [DATA_W-1:0] v2;
        logic [DATA_W-1:0] imm;
        logic [TAG_W-1:0]  q1;
        logic [TAG_W-1:0]  q2;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    typedef struct packed {
        logic [4:0]        op;
        logic [DATA_W-1:0] v1;
        logic [DATA_W-1:0] v2;
        logic [DATA_W-1:0] imm;
        logic [TAG_W-1:0]  tag;
    } issue_t;

    // A pending operand (q != 0) captures a matching broadcast; cdb0 wins ties, tag 0 never matches.
    function automatic entry_t wake(input entry_t e,
                                   input logic c0v, input logic [TAG_W-1:0] c0t, input logic [DATA_W-1:0] c0d,
                                   input logic c1v, input logic [TAG_W-1:0] c1t, input logic [DATA_W-1:0] c1d);
        entry_t r;
        r = e;
        if (e.q1 != '0) begin
            if (c0v && c0t == e.q1) begin
                r.q1 = '0;
                r.v1 = c0d;
            end else if (c1v && c1t == e.q1) begin
                r.q1 = '0;
                r.v1 = c1d;
            end
        end
        if (e.q2 != '0) begin
            if (c0v && c0t == e.q2) begin
                r.q2 = '0;
                r.v2 = c0d;
            end else if (c1v && c1t == e.q2) begin
                r.q2 = '0;
                r.v2 = c1d;
            end
        end
        return r;
    endfunction

    entry_t            ent_q [DEPTH];
    entry_t            ent_d [DEPTH];
    entry_t            woke  [DEPTH];
    entry_t            in_ent;
    entry_t            in_woke;
    issue_t            out_q;
    issue_t            out_d;
    issue_t            sel_iss;
    logic              out_valid_q;
    logic              out_valid_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [CNT_W-1:0]  tail;
    logic              cand;
    logic              load;
    logic [IDX_W-1:0]  sel;

    always_comb begin
        in_ent     = '0;
        in_ent.op  = in_op;
        in_ent.v1  = in_v1;
        in_ent.v2  = in_v2;
        in_ent.imm = in_imm;
        in_ent.q1  = in_q1;
        in_ent.q2  = in_q2;
        in_ent.tag = in_tag;
    end

    assign in_woke = wake(in_ent, cdb0_valid, cdb0_tag, cdb0_data, cdb1_valid, cdb1_tag, cdb1_data);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wake
            assign woke[gi] = wake(ent_q[gi], cdb0_valid, cdb0_tag, cdb0_data,
                                   cdb1_valid, cdb1_tag, cdb1_data);
        end
    endgenerate

    // Selection uses the registered operand state, so a wakeup at edge E issues at E+1 at the earliest.
    always_comb begin
        cand    = 1'b0;
        sel     = '0;
        sel_iss = '0;
        if (IN_ORDER) begin
            cand = (count_q != '0) && (ent_q[0].q1 == '0) && (ent_q[0].q2 == '0);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!cand && (CNT_W'(i) < count_q) && (ent_q[i].q1 == '0) && (ent_q[i].q2 == '0)) begin
                    cand = 1'b1;
                    sel  = IDX_W'(i);
                end
            end
        end
        sel_iss.op  = ent_q[sel].op;
        sel_iss.v1  = ent_q[sel].v1;
        sel_iss.v2  = ent_q[sel].v2;
        sel_iss.imm = ent_q[sel].imm;
        sel_iss.tag = ent_q[sel].tag;
        load = cand && (!out_valid_q || out_ready);
    end

    always_comb begin
        tail    = count_q - CNT_W'(load);
        count_d = count_q + CNT_W'(push) - CNT_W'(load);
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = woke[i];
            if (load && (IDX_W'(i) >= sel)) begin
                ent_d[i] = woke[(i + 1 < DEPTH) ? i + 1 : i];
            end
            if (push && (CNT_W'(i) == tail)) begin
                ent_d[i] = in_woke;
            end
        end
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (load) begin
            out_d       = sel_iss;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_op    = out_q.op;
    assign out_v1    = out_q.v1;
    assign out_v2    = out_q.v2;
    assign out_imm   = out_q.imm;
    assign out_tag   = out_q.tag;
    assign count     = count_q;
    assign full      = (count_q >= CNT_W'(DEPTH));
endmodule

// File: tb/tb_rs_param.sv
// Directed table-driven bench for rs_param: one vector per clock, inputs driven on the
// falling edge, disp_ready checked before the rising edge and registered outputs after it.
module tb_rs_param;
    logic        clk = 1'b0;
    logic        rst, flush, disp_valid, disp_ready;
    logic [4:0]  disp_op;
    logic [31:0] disp_v1, disp_v2, disp_imm;
    logic [2:0]  disp_q1, disp_q2, disp_tag;
    logic        cdb0_valid, cdb1_valid;
    logic [2:0]  cdb0_tag, cdb1_tag;
    logic [31:0] cdb0_data, cdb1_data;
    logic        alu_valid, alu_ready, mem_valid, mem_ready;
    logic [4:0]  alu_op, mem_op;
    logic [31:0] alu_v1, alu_v2, alu_imm, mem_v1, mem_v2, mem_imm;
    logic [2:0]  alu_tag, mem_tag, alu_count, mem_count;

    always #5 clk = ~clk;

    rs_param dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_v1(disp_v1), .disp_v2(disp_v2), .disp_q1(disp_q1), .disp_q2(disp_q2),
        .disp_imm(disp_imm), .disp_tag(disp_tag),
        .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
        .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_op(alu_op),
        .alu_v1(alu_v1), .alu_v2(alu_v2), .alu_imm(alu_imm), .alu_tag(alu_tag),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_op(mem_op),
        .mem_v1(mem_v1), .mem_v2(mem_v2), .mem_imm(mem_imm), .mem_tag(mem_tag),
        .alu_count(alu_count), .mem_count(mem_count)
    );

    typedef struct {
        logic        rstn, fl, dv, ar, mr;
        logic [4:0]  op;
        logic [2:0]  q1, q2, tag;
        logic [31:0] v1, v2;
        logic        c0v, c1v;
        logic [2:0]  c0t, c1t;
        logic [31:0] c0d, c1d;
        logic        e_dr, e_av, e_mv;
        logic [2:0]  e_atag, e_mtag, e_ac, e_mc;
        logic [31:0] e_av1, e_av2, e_mv1;
    } vec_t;

    localparam logic [4:0] ADD = 5'b00000;
    localparam logic [4:0] LW  = 5'b10100;
    localparam logic [4:0] SW  = 5'b11001;

    vec_t tv[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t NOP();
        vec_t v;
        v = '{default: '0};
        v.rstn = 1'b1;
        v.ar   = 1'b1;
        v.mr   = 1'b1;
        return v;
    endfunction

    function automatic vec_t DSP(input logic [4:0] op, input logic [2:0] q1, input logic [2:0] q2,
                                 input logic [31:0] v1, input logic [31:0] v2, input logic [2:0] tag);
        vec_t v;
        v     = NOP();
        v.dv  = 1'b1;
        v.op  = op;
        v.q1  = q1;
        v.q2  = q2;
        v.v1  = v1;
        v.v2  = v2;
        v.tag = tag;
        return v;
    endfunction

    function automatic vec_t RDY(input vec_t vi, input logic ar, input logic mr);
        vec_t v;
        v    = vi;
        v.ar = ar;
        v.mr = mr;
        return v;
    endfunction

    function automatic vec_t CB0(input vec_t vi, input logic [2:0] t, input logic [31:0] d);
        vec_t v;
        v     = vi;
        v.c0v = 1'b1;
        v.c0t = t;
        v.c0d = d;
        return v;
    endfunction

    function automatic vec_t CB1(input vec_t vi, input logic [2:0] t, input logic [31:0] d);
        vec_t v;
        v     = vi;
        v.c1v = 1'b1;
        v.c1t = t;
        v.c1d = d;
        return v;
    endfunction

    function automatic vec_t FL(input vec_t vi);
        vec_t v;
        v    = vi;
        v.fl = 1'b1;
        return v;
    endfunction

    function automatic vec_t RS(input vec_t vi);
        vec_t v;
        v      = vi;
        v.rstn = 1'b0;
        return v;
    endfunction

    // Appends a vector with its expected disp_ready (pre-edge) and post-edge outputs.
    task automatic E(input vec_t vi, input logic dr,
                     input logic av, input logic [2:0] atag, input logic [31:0] av1, input logic [31:0] av2,
                     input logic mv, input logic [2:0] mtag, input logic [31:0] mv1,
                     input logic [2:0] ac, input logic [2:0] mc);
        vec_t v;
        v        = vi;
        v.e_dr   = dr;
        v.e_av   = av;
        v.e_atag = atag;
        v.e_av1  = av1;
        v.e_av2  = av2;
        v.e_mv   = mv;
        v.e_mtag = mtag;
        v.e_mv1  = mv1;
        v.e_ac   = ac;
        v.e_mc   = mc;
        tv.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        rst        = v.rstn;
        flush      = v.fl;
        disp_valid = v.dv;
        disp_op    = v.op;
        disp_q1    = v.q1;
        disp_q2    = v.q2;
        disp_v1    = v.v1;
        disp_v2    = v.v2;
        disp_imm   = 32'h0;
        disp_tag   = v.tag;
        cdb0_valid = v.c0v;
        cdb0_tag   = v.c0t;
        cdb0_data  = v.c0d;
        cdb1_valid = v.c1v;
        cdb1_tag   = v.c1t;
        cdb1_data  = v.c1d;
        alu_ready  = v.ar;
        mem_ready  = v.mr;
    endtask

    initial begin
        int lat;

        // 1: single ready ADD
        E(DSP(ADD, 0, 0, 5, 7, 3),             1, 0, 0, 0, 0,               0, 0, 0, 1, 0);
        E(NOP(),                               1, 1, 3, 5, 7,               0, 0, 0, 0, 0);
        E(NOP(),                               1, 0, 0, 0, 0,               0, 0, 0, 0, 0);
        // 2: fill ALU with entries waiting on tag 2; ALU full, LW still accepted
        E(DSP(ADD, 2, 0, 0, 32'h10, 1),        1, 0, 0, 0, 0,               0, 0, 0, 1, 0);
        E(DSP(ADD, 2, 0, 0, 32'h11, 2),        1, 0, 0, 0, 0,               0, 0, 0, 2, 0);
        E(DSP(ADD, 2, 0, 0, 32'h12, 3),        1, 0, 0, 0, 0,               0, 0, 0, 3, 0);
        E(DSP(ADD, 2, 0, 0, 32'h13, 4),        1, 0, 0, 0, 0,               0, 0, 0, 4, 0);
        E(DSP(ADD, 0, 0, 1, 1, 5),             0, 0, 0, 0, 0,               0, 0, 0, 4, 0);
        E(DSP(LW, 0, 0, 32'h200, 0, 5),        1, 0, 0, 0, 0,               0, 0, 0, 4, 1);
        E(CB0(NOP(), 2, 32'hAA),               0, 0, 0, 0, 0,               1, 5, 32'h200, 4, 0);
        E(NOP(),                               0, 1, 1, 32'hAA, 32'h10,     0, 0, 0, 3, 0);
        E(NOP(),                               1, 1, 2, 32'hAA, 32'h11,     0, 0, 0, 2, 0);
        E(NOP(),                               1, 1, 3, 32'hAA, 32'h12,     0, 0, 0, 1, 0);
        E(NOP(),                               1, 1, 4, 32'hAA, 32'h13,     0, 0, 0, 0, 0);
        E(NOP(),                               1, 0, 0, 0, 0,               0, 0, 0, 0, 0);
        // 3: memory strictly in order behind an unready head
        E(DSP(LW, 4, 0, 0, 0, 6),              1, 0, 0, 0, 0,               0, 0, 0, 0, 1);
        E(DSP(SW, 0, 0, 32'h300, 32'h44, 7),   1, 0, 0, 0, 0,               0, 0, 0, 0, 2);
        E(NOP(),                               1, 0, 0, 0, 0,               0, 0, 0, 0, 2);
        E(CB1(NOP(), 4, 32'h100),              1, 0, 0, 0, 0,               0, 0, 0, 0, 2);
        E(NOP(),                               1, 0, 0, 0, 0,               1, 6, 32'h100, 0, 1);
        E(NOP(),                               1, 0, 0, 0, 0,               1, 7, 32'h300, 0, 0);
        E(NOP(),                               1, 0, 0, 0, 0,               0, 0, 0, 0, 0);
        // 4: dispatch-time bypass, cdb0 wins over cdb1
        E(CB0(DSP(ADD, 0, 5, 1, 0, 1), 5, 32'h33), 1, 0, 0, 0, 0,           0, 0, 0, 1, 0);
        E(NOP(),                               1, 1, 1, 1, 32'h33,          0, 0, 0, 0, 0);
        E(CB1(CB0(DSP(ADD, 0, 5, 2, 0, 2), 5, 32'h33), 5, 32'h55), 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        E(NOP(),                               1, 1, 2, 2, 32'h33,          0, 0, 0, 0, 0);
        E(NOP(),                               1, 0, 0, 0, 0,               0, 0, 0, 0, 0);
        // 5: backpressure holds the output; same-edge issue and dispatch
        E(RDY(DSP(ADD, 0, 0, 32'hA, 32'hB, 1), 0, 1), 1, 0, 0, 0, 0,        0, 0, 0, 1, 0);
        E(RDY(DSP(ADD, 0, 0, 32'hC, 32'hD, 2), 0, 1), 1, 1, 1, 32'hA, 32'hB, 0, 0, 0, 1, 0);
        E(RDY(NOP(), 0, 1),                    1, 1, 1, 32'hA, 32'hB,       0, 0, 0, 1, 0);
        E(RDY(NOP(), 0, 1),                    1, 1, 1, 32'hA, 32'hB,       0, 0, 0, 1, 0);
        E(RDY(NOP(), 0, 1),                    1, 1, 1, 32'hA, 32'hB,       0, 0, 0, 1, 0);
        E(NOP(),                               1, 1, 2, 32'hC, 32'hD,       0, 0, 0, 0, 0);
        E(NOP(),                               1, 0, 0, 0, 0,               0, 0, 0, 0, 0);
        // younger ready ALU entry overtakes an older unready one
        E(DSP(ADD, 6, 0, 0, 0, 3),             1, 0, 0, 0, 0,               0, 0, 0, 1, 0);
        E(DSP(ADD, 0, 0, 32'h77, 32'h88, 4),   1, 0, 0, 0, 0,               0, 0, 0, 2, 0);
        E(NOP(),                               1, 1, 4, 32'h77, 32'h88,     0, 0, 0, 1, 0);
        E(CB0(NOP(), 6, 32'h99),               1, 0, 0, 0, 0,               0, 0, 0, 1, 0);
        E(NOP(),                               1, 1, 3, 32'h99, 0,          0, 0, 0, 0, 0);
        E(NOP(),                               1, 0, 0, 0, 0,               0, 0, 0, 0, 0);
        // 6a: flush with both outputs valid and 3 entries; dispatch during flush dropped
        E(RDY(DSP(ADD, 0, 0, 1, 1, 1), 0, 1),  1, 0, 0, 0, 0,               0, 0, 0, 1, 0);
        E(RDY(DSP(ADD, 0, 0, 2, 2, 2), 0, 1),  1, 1, 1, 1, 1,               0, 0, 0, 1, 0);
        E(RDY(DSP(LW, 0, 0, 32'h10, 0, 5), 0, 0), 1, 1, 1, 1, 1,            0, 0, 0, 1, 1);
        E(RDY(DSP(ADD, 0, 0, 3, 3, 3), 0, 0),  1, 1, 1, 1, 1,               1, 5, 32'h10, 2, 0);
        E(RDY(DSP(LW, 7, 0, 0, 0, 6), 0, 0),   1, 1, 1, 1, 1,               1, 5, 32'h10, 2, 1);
        E(FL(DSP(ADD, 0, 0, 9, 9, 4)),         0, 0, 0, 0, 0,               0, 0, 0, 0, 0);
        E(NOP(),                               1, 0, 0, 0, 0,               0, 0, 0, 0, 0);
        // 6b: synchronous reset mid-stream
        E(RDY(DSP(ADD, 0, 0, 1, 1, 1), 0, 1),  1, 0, 0, 0, 0,               0, 0, 0, 1, 0);
        E(RDY(DSP(ADD, 0, 0, 2, 2, 2), 0, 1),  1, 1, 1, 1, 1,               0, 0, 0, 1, 0);
        E(RDY(DSP(LW, 0, 0, 32'h20, 0, 5), 0, 1), 1, 1, 1, 1, 1,            0, 0, 0, 1, 1);
        E(RS(RDY(DSP(ADD, 0, 0, 3, 3, 3), 0, 1)), 1, 0, 0, 0, 0,            0, 0, 0, 0, 0);
        E(RDY(NOP(), 0, 1),                    1, 0, 0, 0, 0,               0, 0, 0, 0, 0);

        // initial reset and reset-state check
        drive(RS(NOP()));
        repeat (2) @(posedge clk);
        #1;
        chk("reset alu_valid", alu_valid, 0);
        chk("reset mem_valid", mem_valid, 0);
        chk("reset alu_count", alu_count, 0);
        chk("reset mem_count", mem_count, 0);
        chk("reset alu_tag",   alu_tag, 0);
        chk("reset mem_v1",    mem_v1, 0);

        foreach (tv[i]) begin
            @(negedge clk);
            drive(tv[i]);
            #1;
            chk($sformatf("v%0d disp_ready", i), disp_ready, tv[i].e_dr);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d alu_valid", i), alu_valid, tv[i].e_av);
            chk($sformatf("v%0d mem_valid", i), mem_valid, tv[i].e_mv);
            chk($sformatf("v%0d alu_count", i), alu_count, tv[i].e_ac);
            chk($sformatf("v%0d mem_count", i), mem_count, tv[i].e_mc);
            if (tv[i].e_av) begin
                chk($sformatf("v%0d alu_tag", i), alu_tag, tv[i].e_atag);
                chk($sformatf("v%0d alu_v1", i),  alu_v1,  tv[i].e_av1);
                chk($sformatf("v%0d alu_v2", i),  alu_v2,  tv[i].e_av2);
            end
            if (tv[i].e_mv) begin
                chk($sformatf("v%0d mem_tag", i), mem_tag, tv[i].e_mtag);
                chk($sformatf("v%0d mem_v1", i),  mem_v1,  tv[i].e_mv1);
            end
        end

        // memory wakeup latency: broadcast at edge E, issue visible after E+1
        @(negedge clk);
        drive(DSP(LW, 3, 0, 0, 0, 2));
        @(negedge clk);
        drive(CB0(NOP(), 3, 32'h5A));
        @(negedge clk);
        drive(NOP());
        lat = -1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            if (mem_valid) begin
                lat = c;
                break;
            end
        end
        chk("wake latency", lat, 1);
        chk("wake mem_v1",  mem_v1, 32'h5A);
        chk("wake mem_tag", mem_tag, 2);
        chk("wake mem_op",  mem_op, LW);

        // reset clears issue data registers, not only valid
        @(negedge clk);
        drive(RS(NOP()));
        @(posedge clk);
        #1;
        chk("rst mem_valid", mem_valid, 0);
        chk("rst mem_tag",   mem_tag, 0);
        chk("rst mem_v1",    mem_v1, 0);
        chk("rst mem_op",    mem_op, 0);
        chk("rst alu_tag",   alu_tag, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
